mem_store_issue: RTL and testbench
==================================

MEM_STORE_ISSUE -- requirements
Module: mem_store_issue

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-003 The block SHALL have port CSR_reset, input, 1 bit: pipeline flush request.
REQ-004 The block SHALL have port MEM_store_req, input, 1 bit: MEM stage holds a store instruction.
REQ-005 The block SHALL have port MEM_funct3, input, 3 bits: store width; 0=SB, 1=SH, 2=SW/FSW.
REQ-006 The block SHALL have port MEM_addr, input, 32 bits: byte address of the store.
REQ-007 The block SHALL have port MEM_rs2_data, input, 32 bits: store source data, LSB-aligned.
REQ-008 The block SHALL have port DM_ack, input, 1 bit: data memory has accepted the write.
REQ-009 The block SHALL have port DM_req, output, 1 bit: write request to data memory.
REQ-010 The block SHALL have port DM_addr, output, 32 bits: word-aligned write address.
REQ-011 The block SHALL have port DM_wdata, output, 32 bits: lane-replicated write data.
REQ-012 The block SHALL have port DM_wstrb, output, 4 bits: active-high byte enables, bit i = byte lane i.
REQ-013 The block SHALL have port st_stall, output, 1 bit: pipeline hold request, ORed with im_stall/dm_stall/CSR_stall.
REQ-014 The block SHALL have port st_fault, output, 1 bit: one-cycle pulse for a misaligned or illegal store.

Function
REQ-015 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-016 A store SHALL be legal when funct3=0; when funct3=1 and addr[0]=0; or when funct3=2 and addr[1:0]=0.
REQ-017 In IDLE, when MEM_store_req=1, CSR_reset=0 and the store is legal, the block SHALL register DM_addr={addr[31:2],2'b00}, DM_wdata, DM_wstrb and DM_req=1, and SHALL enter BUSY on the next edge.
REQ-018 For SB, the block SHALL drive wdata={4{rs2[7:0]}} and wstrb=4'b0001<<addr[1:0].
REQ-019 For SH, the block SHALL drive wdata={2{rs2[15:0]}} and wstrb=addr[1]?4'b1100:4'b0011.
REQ-020 For SW, the block SHALL drive wdata=rs2 and wstrb=4'b1111.
REQ-021 In BUSY, DM_req, DM_addr, DM_wdata and DM_wstrb SHALL be held stable until the cycle DM_ack=1 is sampled.
REQ-022 When DM_ack=1 is sampled in BUSY, the block SHALL clear DM_req on that edge and return to IDLE.
REQ-023 DM_ack while in IDLE SHALL be ignored.
REQ-024 st_stall SHALL be combinational: (IDLE & MEM_store_req & legal & ~CSR_reset) | (BUSY & ~DM_ack).
REQ-025 Store latency SHALL be: request visible 1 cycle after acceptance; stall released in the DM_ack cycle.
REQ-026 In IDLE, a store that is not legal SHALL issue no request, SHALL NOT stall, and SHALL set st_fault=1 for exactly the next cycle.
REQ-027 st_fault SHALL pulse once per instruction; if an illegal MEM_store_req is held across an external stall, the pulse SHALL NOT repeat.
REQ-028 A new acceptance SHALL be possible in the IDLE cycle that immediately follows the ack edge, giving back-to-back stores a 2-cycle minimum spacing when memory acks immediately.
REQ-029 CSR_reset in IDLE SHALL block acceptance and fault generation.
REQ-030 CSR_reset in BUSY SHALL NOT abort the transaction: the request is held until DM_ack, then the block returns to IDLE.
REQ-031 During BUSY, MEM_store_req, MEM_addr and MEM_rs2_data changes SHALL have no effect on the outputs.

Reset
REQ-032 On reset=1 at a clock edge, the FSM SHALL go to IDLE and DM_req, DM_addr, DM_wdata, DM_wstrb and st_fault SHALL all be 0.
REQ-033 Reset SHALL override all other inputs, including mid-BUSY; an outstanding request is dropped.
REQ-034 st_stall SHALL be 0 while reset is held unless MEM_store_req is legal.

Verification
REQ-035 The bench SHALL check SB, addr=0x1003, rs2=0x000000A5 -> DM_addr=0x1000, wdata=0xA5A5A5A5, wstrb=1000, DM_req 1 cycle later.
REQ-036 The bench SHALL check SH, addr=0x2002, rs2=0x1234BEEF -> wdata=0xBEEFBEEF, wstrb=1100; with DM_ack delayed 3 cycles, st_stall=1 for 4 cycles and outputs stay stable.
REQ-037 The bench SHALL check SW, addr=0x3001 -> no DM_req, st_stall=0, st_fault=1 for one cycle; funct3=3 gives the same response.
REQ-038 The bench SHALL check two SW stores with immediate ack -> DM_req pulses 1 cycle each, separated by 1 idle cycle, correct data for each.
REQ-039 The bench SHALL check CSR_reset in BUSY -> DM_req held until DM_ack, then IDLE; CSR_reset with a store request in IDLE -> no request.
REQ-040 The bench SHALL check reset asserted in BUSY -> next cycle DM_req=0, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_store_issue_if.sv
// Store-issue handshake bundle between the MEM stage, data memory and the hazard unit.
//   master : MEM-stage/memory side (drives requests, flush and ack; observes DM_* and stall/fault)
//   slave  : mem_store_issue (observes requests; drives DM_* and stall/fault)
interface mem_store_issue_if;
  logic        CSR_reset;
  logic        MEM_store_req;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_rs2_data;
  logic        DM_ack;
  logic        DM_req;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [3:0]  DM_wstrb;
  logic        st_stall;
  logic        st_fault;

  modport master (
    output CSR_reset, MEM_store_req, MEM_funct3, MEM_addr, MEM_rs2_data, DM_ack,
    input  DM_req, DM_addr, DM_wdata, DM_wstrb, st_stall, st_fault
  );

  modport slave (
    input  CSR_reset, MEM_store_req, MEM_funct3, MEM_addr, MEM_rs2_data, DM_ack,
    output DM_req, DM_addr, DM_wdata, DM_wstrb, st_stall, st_fault
  );
endinterface

// File: rtl/mem_store_issue.sv
// Store issue unit: turns a MEM-stage store into a single registered data-memory
// write request, holds it until DM_ack, and flags misaligned/illegal stores.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mem_store_issue_if.slave (MEM request in, DM request out, stall/fault)
module mem_store_issue (
  input  logic             clk,
  input  logic             reset,
  mem_store_issue_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        fault_q, fault_d;
  logic        fault_seen_q, fault_seen_d;

  logic        legal;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic        stall;

  // Legality and lane steering of the store currently presented by MEM.
  always_comb begin
    legal      = 1'b0;
    lane_wdata = bus.MEM_rs2_data;
    lane_wstrb = '0;
    case (bus.MEM_funct3)
      3'd0: begin
        legal      = 1'b1;
        lane_wdata = {4{bus.MEM_rs2_data[7:0]}};
        lane_wstrb = 4'b0001 << bus.MEM_addr[1:0];
      end
      3'd1: begin
        legal      = ~bus.MEM_addr[0];
        lane_wdata = {2{bus.MEM_rs2_data[15:0]}};
        lane_wstrb = bus.MEM_addr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        legal      = (bus.MEM_addr[1:0] == 2'b00);
        lane_wdata = bus.MEM_rs2_data;
        lane_wstrb = '1;
      end
      default: begin
        legal      = 1'b0;
        lane_wdata = bus.MEM_rs2_data;
        lane_wstrb = '0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    fault_d      = 1'b0;
    fault_seen_d = 1'b0;
    stall        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MEM_store_req && !bus.CSR_reset) begin
          if (legal) begin
            state_d = BUSY;
            req_d   = 1'b1;
            addr_d  = {bus.MEM_addr[31:2], 2'b00};
            wdata_d = lane_wdata;
            wstrb_d = lane_wstrb;
            stall   = 1'b1;
          end else begin
            // An illegal store held in MEM by an unrelated stall faults only once;
            // the marker clears as soon as MEM stops presenting it or a flush arrives.
            fault_d      = ~fault_seen_q;
            fault_seen_d = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = ~bus.DM_ack & ~reset;
        if (bus.DM_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      fault_q      <= 1'b0;
      fault_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      fault_q      <= fault_d;
      fault_seen_q <= fault_seen_d;
    end
  end

  assign bus.DM_req   = req_q;
  assign bus.DM_addr  = addr_q;
  assign bus.DM_wdata = wdata_q;
  assign bus.DM_wstrb = wstrb_q;
  assign bus.st_fault = fault_q;
  assign bus.st_stall = stall;
endmodule

// File: tb/tb_mem_store_issue.sv
// Bench for mem_store_issue: fixed vector table, directed multi-cycle sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_store_issue;
  logic clk = 1'b0;
  logic reset;
  mem_store_issue_if bus();

  mem_store_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  // Reference model: one outstanding write transaction plus the fault pulse.
  bit          m_valid = 1'b0;
  bit          m_busy;
  bit          m_req;
  bit [31:0]   m_addr;
  bit [31:0]   m_wdata;
  bit [3:0]    m_wstrb;
  bit          m_fault;
  bit          m_fdone;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic        legal;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wstrb;
  } tvec_t;

  tvec_t tv[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void lanes(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                output bit ok, output bit [31:0] wd, output bit [3:0] sb);
    ok = 1'b0;
    wd = '0;
    sb = '0;
    if (f3 == 3'd0) begin
      ok = 1'b1;
      wd = {24'h0, d[7:0]} * 32'h0101_0101;
      sb = 4'(1 << (a % 4));
    end else if (f3 == 3'd1) begin
      ok = ((a % 2) == 0);
      wd = {16'h0, d[15:0]} * 32'h0001_0001;
      sb = ((a % 4) >= 2) ? 4'hC : 4'h3;
    end else if (f3 == 3'd2) begin
      ok = ((a % 4) == 0);
      wd = d;
      sb = 4'hF;
    end
  endfunction

  // One cycle: drive inputs after the falling edge, compare against the model,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input logic sreq, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input logic ack, input logic csr, input logic rst);
    bit        ok;
    bit [31:0] wd;
    bit [3:0]  sb;
    bit        exp_stall;
    @(negedge clk);
    bus.MEM_store_req = sreq;
    bus.MEM_funct3    = f3;
    bus.MEM_addr      = a;
    bus.MEM_rs2_data  = d;
    bus.DM_ack        = ack;
    bus.CSR_reset     = csr;
    reset             = rst;
    #1;
    lanes(f3, a, d, ok, wd, sb);
    if (m_valid) begin
      exp_stall = m_busy ? (!ack && !rst) : (sreq && ok && !csr);
      chk("m_stall", 32'(bus.st_stall), 32'(exp_stall));
      chk("m_req",   32'(bus.DM_req),   32'(m_req));
      chk("m_fault", 32'(bus.st_fault), 32'(m_fault));
      chk("m_addr",  bus.DM_addr,       m_addr);
      chk("m_wdata", bus.DM_wdata,      m_wdata);
      chk("m_wstrb", 32'(bus.DM_wstrb), 32'(m_wstrb));
    end
    if (rst) begin
      m_valid = 1'b1; m_busy = 1'b0; m_req = 1'b0; m_addr = '0;
      m_wdata = '0;   m_wstrb = '0;  m_fault = 1'b0; m_fdone = 1'b0;
    end else if (m_valid) begin
      m_fault = 1'b0;
      if (m_busy) begin
        m_fdone = 1'b0;
        if (ack) begin
          m_busy = 1'b0;
          m_req  = 1'b0;
        end
      end else if (sreq && !csr && ok) begin
        m_busy  = 1'b1;
        m_req   = 1'b1;
        m_addr  = a & 32'hFFFF_FFFC;
        m_wdata = wd;
        m_wstrb = sb;
        m_fdone = 1'b0;
      end else if (sreq && !csr) begin
        m_fault = !m_fdone;
        m_fdone = 1'b1;
      end else begin
        m_fdone = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 3'd0, '0, '0, ack, 1'b0, 1'b0);
  endtask

  int unsigned stalls;

  initial begin
    bus.MEM_store_req = 1'b0; bus.MEM_funct3 = '0; bus.MEM_addr = '0;
    bus.MEM_rs2_data = '0; bus.DM_ack = 1'b0; bus.CSR_reset = 1'b0; reset = 1'b1;

    tv[0]  = '{3'd0, 32'h0000_1000, 32'h0000_0037, 1'b1, 32'h0000_1000, 32'h3737_3737, 32'h1};
    tv[1]  = '{3'd0, 32'h0000_1001, 32'hFFFF_FF5A, 1'b1, 32'h0000_1000, 32'h5A5A_5A5A, 32'h2};
    tv[2]  = '{3'd0, 32'h0000_1002, 32'h1234_5680, 1'b1, 32'h0000_1000, 32'h8080_8080, 32'h4};
    tv[3]  = '{3'd0, 32'h8000_0003, 32'h0000_00C3, 1'b1, 32'h8000_0000, 32'hC3C3_C3C3, 32'h8};
    tv[4]  = '{3'd1, 32'h0000_2000, 32'hAAAA_1357, 1'b1, 32'h0000_2000, 32'h1357_1357, 32'h3};
    tv[5]  = '{3'd1, 32'h0000_2002, 32'h0000_BEEF, 1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 32'hC};
    tv[6]  = '{3'd1, 32'h0000_2003, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[7]  = '{3'd2, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'hF};
    tv[8]  = '{3'd2, 32'h0000_3002, 32'h0BAD_F00D, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[9]  = '{3'd4, 32'h0000_4000, 32'h1111_1111, 1'b0, 32'h0, 32'h0, 32'h0};
    tv[10] = '{3'd7, 32'h0000_5000, 32'h2222_2222, 1'b0, 32'h0, 32'h0, 32'h0};

    // Reset state.
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_req",   32'(bus.DM_req), 0);
    chk("rst_fault", 32'(bus.st_fault), 0);
    chk("rst_addr",  bus.DM_addr, 0);
    chk("rst_wdata", bus.DM_wdata, 0);
    chk("rst_wstrb", 32'(bus.DM_wstrb), 0);

    // Vector table: one store, immediate ack on the request cycle, one idle cycle.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, tv[i].f3, tv[i].addr, tv[i].rs2, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tv%0d_stall", i), 32'(bus.st_stall), 32'(tv[i].legal));
      step(1'b0, 3'd0, '0, '0, tv[i].legal, 1'b0, 1'b0);
      chk($sformatf("tv%0d_req", i),   32'(bus.DM_req),   32'(tv[i].legal));
      chk($sformatf("tv%0d_fault", i), 32'(bus.st_fault), 32'(!tv[i].legal));
      if (tv[i].legal) begin
        chk($sformatf("tv%0d_addr", i),  bus.DM_addr,  tv[i].exp_addr);
        chk($sformatf("tv%0d_wdata", i), bus.DM_wdata, tv[i].exp_wdata);
        chk($sformatf("tv%0d_wstrb", i), 32'(bus.DM_wstrb), tv[i].exp_wstrb);
      end
      idle(1'b0);
      chk($sformatf("tv%0d_done", i), 32'(bus.DM_req | bus.st_fault), 0);
    end

    // SB to byte lane 3.
    step(1'b1, 3'd0, 32'h1003, 32'hA5, 1'b0, 1'b0, 1'b0);
    chk("sb_stall", 32'(bus.st_stall), 1);
    chk("sb_req_early", 32'(bus.DM_req), 0);
    idle(1'b1);
    chk("sb_req", 32'(bus.DM_req), 1);
    chk("sb_addr", bus.DM_addr, 32'h1000);
    chk("sb_wdata", bus.DM_wdata, 32'hA5A5_A5A5);
    chk("sb_wstrb", 32'(bus.DM_wstrb), 32'h8);
    idle(1'b0);
    chk("sb_req_clr", 32'(bus.DM_req), 0);

    // SH with ack three cycles after the request appears; MEM inputs churn meanwhile.
    stalls = 0;
    step(1'b1, 3'd1, 32'h2002, 32'h1234_BEEF, 1'b0, 1'b0, 1'b0);
    if (bus.st_stall) stalls++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'($urandom_range(0, 3)), $urandom, $urandom, 1'b0, 1'b0, 1'b0);
      if (bus.st_stall) stalls++;
      chk("sh_hold_wdata", bus.DM_wdata, 32'hBEEF_BEEF);
      chk("sh_hold_wstrb", 32'(bus.DM_wstrb), 32'hC);
      chk("sh_hold_addr", bus.DM_addr, 32'h2000);
    end
    step(1'b1, 3'd1, 32'h2002, 32'h1234_BEEF, 1'b1, 1'b0, 1'b0);
    if (bus.st_stall) stalls++;
    chk("sh_ack_req", 32'(bus.DM_req), 1);
    chk("sh_stall_cycles", 32'(stalls), 4);
    idle(1'b0);
    chk("sh_req_clr", 32'(bus.DM_req), 0);

    // Misaligned SW and funct3=3: no request, no stall, single-cycle fault.
    step(1'b1, 3'd2, 32'h3001, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
    chk("sw_mis_stall", 32'(bus.st_stall), 0);
    idle(1'b0);
    chk("sw_mis_fault", 32'(bus.st_fault), 1);
    chk("sw_mis_req", 32'(bus.DM_req), 0);
    idle(1'b0);
    chk("sw_mis_fault_end", 32'(bus.st_fault), 0);
    step(1'b1, 3'd3, 32'h3000, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
    chk("f3_3_stall", 32'(bus.st_stall), 0);
    idle(1'b0);
    chk("f3_3_fault", 32'(bus.st_fault), 1);
    chk("f3_3_req", 32'(bus.DM_req), 0);

    // Illegal store held in MEM for three cycles faults once.
    for (int i = 0; i < 3; i++) step(1'b1, 3'd1, 32'h4001, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("held_fault_no_repeat", 32'(bus.st_fault), 0);

    // Back-to-back SW with immediate ack.
    step(1'b1, 3'd2, 32'h5000, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 32'h5000, 32'h1111_2222, 1'b1, 1'b0, 1'b0);
    chk("b2b_req1", 32'(bus.DM_req), 1);
    chk("b2b_wdata1", bus.DM_wdata, 32'h1111_2222);
    step(1'b1, 3'd2, 32'h5004, 32'h3333_4444, 1'b0, 1'b0, 1'b0);
    chk("b2b_gap", 32'(bus.DM_req), 0);
    chk("b2b_accept2", 32'(bus.st_stall), 1);
    idle(1'b1);
    chk("b2b_req2", 32'(bus.DM_req), 1);
    chk("b2b_addr2", bus.DM_addr, 32'h5004);
    chk("b2b_wdata2", bus.DM_wdata, 32'h3333_4444);
    idle(1'b0);

    // Flush during BUSY does not abort; flush in IDLE blocks acceptance and faults.
    step(1'b1, 3'd2, 32'h6000, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 32'h6000, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0);
    chk("csr_busy_req", 32'(bus.DM_req), 1);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("csr_busy_hold", 32'(bus.DM_req), 1);
    step(1'b0, 3'd0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("csr_busy_ack", 32'(bus.DM_req), 1);
    step(1'b1, 3'd2, 32'h7000, 32'h1, 1'b0, 1'b1, 1'b0);
    chk("csr_idle_req_gone", 32'(bus.DM_req), 0);
    chk("csr_idle_stall", 32'(bus.st_stall), 0);
    step(1'b1, 3'd2, 32'h7001, 32'h1, 1'b0, 1'b1, 1'b0);
    chk("csr_idle_no_req", 32'(bus.DM_req), 0);
    idle(1'b0);
    chk("csr_idle_no_fault", 32'(bus.st_fault), 0);

    // Reset in BUSY drops the request; next store is accepted from IDLE.
    step(1'b1, 3'd0, 32'h8001, 32'h77, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("rb_req", 32'(bus.DM_req), 1);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rb_stall_in_reset", 32'(bus.st_stall), 0);
    step(1'b1, 3'd2, 32'h9000, 32'h9, 1'b0, 1'b0, 1'b0);
    chk("rb_req_clr", 32'(bus.DM_req), 0);
    chk("rb_addr_clr", bus.DM_addr, 0);
    chk("rb_wdata_clr", bus.DM_wdata, 0);
    chk("rb_wstrb_clr", 32'(bus.DM_wstrb), 0);
    chk("rb_fault_clr", 32'(bus.st_fault), 0);
    chk("rb_idle_accept", 32'(bus.st_stall), 1);
    idle(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), $urandom, $urandom,
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
